// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port, asynchronous-read memory: sequences write/read bursts as single beats.
// Optional macro MEM_BURST_WRAP_ERR_EN adds an `err` output flagging bursts that wrap past the top address.
module mem_burst_master #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_enb,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done
`ifdef MEM_BURST_WRAP_ERR_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic                done_q, done_d;
  logic                cmd_fire;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    cmd_fire    = 1'b0;
    wdata_ready = 1'b0;
    mem_wr_enb  = 1'b0;

    // A pending read beat drains in any state; a capture below overrides the clear.
    if (rvalid_q && rdata_ready) begin
      rvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cmd_ready = !rvalid_q;
        cmd_fire  = cmd_valid && !rvalid_q;
        if (cmd_fire) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_wr ? WR : RD;
        end
      end
      WR: begin
        wdata_ready = 1'b1;
        mem_wr_enb  = wdata_valid;
        if (wdata_valid) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        if (!rvalid_q || rdata_ready) begin
          rdata_d  = mem_rd_data;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == '0);
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      done_q   <= done_d;
    end
  end

`ifdef MEM_BURST_WRAP_ERR_EN
  logic              err_q;
  logic [ADDR_W:0]   end_addr;

  // Last beat address at one extra bit; the carry means the burst wraps.
  assign end_addr = (ADDR_W+1)'(cmd_addr) + (ADDR_W+1)'(cmd_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (cmd_fire) begin
      err_q <= end_addr[ADDR_W];
    end
  end

  assign err = err_q;
`endif

  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign rdata_last  = rlast_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed self-checking bench for mem_burst_master with a behavioural async-read memory attached.
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_ready, rdata_last;
  logic [7:0] rdata;
  logic [3:0] mem_addr;
  logic       mem_wr_enb;
  logic [7:0] mem_wr_data, mem_rd_data;
  logic       busy, done;
`ifdef MEM_BURST_WRAP_ERR_EN
  logic       err;
`endif

  logic [7:0] mem [16];
  int         wr_count = 0;
  int         checks   = 0;
  int         failures = 0;

  mem_burst_master #(.ADDR_W(4), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rdata(rdata), .rdata_last(rdata_last),
    .mem_addr(mem_addr), .mem_wr_enb(mem_wr_enb),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done)
`ifdef MEM_BURST_WRAP_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_enb) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [3:0] a, input logic [3:0] l);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    #1;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_wdata_ready"}, wdata_ready, 0);
    chk({tag, "_rdata_valid"}, rdata_valid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rdata_last"}, rdata_last, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wr_enb"}, mem_wr_enb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef MEM_BURST_WRAP_ERR_EN
    chk({tag, "_err"}, err, 0);
`endif
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    #2;
    chk_reset_outputs("reset");
    #10 rst_n = 1'b1;
    tick();

    // Write burst 0x2, 4 beats A1..A4 back-to-back
    wdata_valid = 1'b1; wdata = 8'hA1;
    issue(1'b1, 4'h2, 4'd3);
    for (int i = 0; i < 4; i++) begin
      wdata = 8'hA1 + 8'(i);
      #1;
      chk("wr_mem_addr", mem_addr, 2 + i);
      chk("wr_enb", mem_wr_enb, 1);
      chk("wr_wdata_ready", wdata_ready, 1);
      chk("wr_done_early", done, 0);
      tick();
    end
    wdata_valid = 1'b0;
    chk("wr_done_pulse", done, 1);
    chk("wr_idle_cmd_ready", cmd_ready, 1);
    chk("wr_idle_wdata_ready", wdata_ready, 0);
    for (int i = 0; i < 4; i++) chk("wr_mem_content", mem[2 + i], 8'hA1 + 8'(i));
    tick();
    chk("wr_done_single", done, 0);

    // Read burst 0x2, 4 beats, sink always ready
    rdata_ready = 1'b1;
    issue(1'b0, 4'h2, 4'd3);
    chk("rd_first_addr", mem_addr, 2);
    chk("rd_no_data_yet", rdata_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_valid", rdata_valid, 1);
      chk("rd_data", rdata, 8'hA1 + 8'(i));
      chk("rd_last", rdata_last, (i == 3) ? 1 : 0);
      chk("rd_done", done, (i == 3) ? 1 : 0);
    end
    chk("rd_cmd_blocked_until_consumed", cmd_ready, 0);
    tick();
    chk("rd_drained_valid", rdata_valid, 0);
    chk("rd_drained_done", done, 0);
    chk("rd_drained_cmd_ready", cmd_ready, 1);

    // Read with 3-cycle back-pressure on beat 2
    issue(1'b0, 4'h2, 4'd3);
    tick();
    chk("bp_beat1", rdata, 8'hA1);
    tick();
    chk("bp_beat2", rdata, 8'hA2);
    chk("bp_addr", mem_addr, 4);
    rdata_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", rdata, 8'hA2);
      chk("bp_hold_valid", rdata_valid, 1);
      chk("bp_hold_addr", mem_addr, 4);
      chk("bp_hold_done", done, 0);
    end
    rdata_ready = 1'b1;
    tick();
    chk("bp_beat3", rdata, 8'hA3);
    chk("bp_beat3_last", rdata_last, 0);
    tick();
    chk("bp_beat4", rdata, 8'hA4);
    chk("bp_beat4_last", rdata_last, 1);
    chk("bp_done", done, 1);
    tick();
    chk("bp_drained", rdata_valid, 0);

    // Wrapping write 0xE, 3 beats
    wdata_valid = 1'b1; wdata = 8'h11;
    issue(1'b1, 4'hE, 4'd2);
`ifdef MEM_BURST_WRAP_ERR_EN
    chk("wrap_err_set", err, 1);
`endif
    tick();
    wdata = 8'h22;
    tick();
    wdata = 8'h33;
    #1;
    chk("wrap_addr_zero", mem_addr, 0);
    tick();
    wdata_valid = 1'b0;
    chk("wrap_done", done, 1);
    chk("wrap_mem_e", mem[14], 8'h11);
    chk("wrap_mem_f", mem[15], 8'h22);
    chk("wrap_mem_0", mem[0], 8'h33);
    wdata_valid = 1'b1;
    issue(1'b1, 4'h0, 4'd0);
`ifdef MEM_BURST_WRAP_ERR_EN
    chk("wrap_err_clear", err, 0);
`endif
    tick();
    wdata_valid = 1'b0;
    chk("single_done", done, 1);
    chk("single_mem_0", mem[0], 8'h33);

    // Write with 2-cycle gaps between beats at 0x8
    base = wr_count;
    wdata_valid = 1'b1; wdata = 8'h50;
    issue(1'b1, 4'h8, 4'd2);
    for (int b = 0; b < 3; b++) begin
      wdata_valid = 1'b1; wdata = 8'h50 + 8'(b);
      tick();
      if (b < 2) begin
        wdata_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          #1;
          chk("gap_no_write", mem_wr_enb, 0);
          chk("gap_ready", wdata_ready, 1);
          chk("gap_addr", mem_addr, 8 + b + 1);
          tick();
        end
      end
    end
    wdata_valid = 1'b0;
    chk("gap_done", done, 1);
    chk("gap_write_count", wr_count - base, 3);
    chk("gap_mem_8", mem[8], 8'h50);
    chk("gap_mem_9", mem[9], 8'h51);
    chk("gap_mem_a", mem[10], 8'h52);
    tick();

    // Reset asserted mid read burst
    rdata_ready = 1'b1;
    issue(1'b0, 4'h2, 4'd3);
    tick();
    chk("rst_beat1", rdata, 8'hA1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mem_kept", mem[2], 8'hA1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator side of the single-port asynchronous-read memory interface. Accepts burst commands (write or read, start address, beat count) on a valid/ready port and sequences single-beat accesses onto the memory's `addr`/`wr_enb`/`wr_data`/`rd_data` pins. Write data streams in, and read data streams out, through valid/ready handshakes. It sits between a client datapath and the `memory` instance, on the same clock.

## Interface
- `ADDR_W`, 4: memory address width; memory depth is 2^ADDR_W.
- `DATA_W`, 8: memory data width.
- `LEN_W`, 4: burst length field width; a burst is `cmd_len+1` beats.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when valid & ready.
- `cmd_wr` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start address.
- `cmd_len` in LEN_W: beats minus one.
- `wdata_valid` in 1: write beat offered.
- `wdata_ready` out 1: write beat consumed when valid & ready.
- `wdata` in DATA_W: write beat data.
- `rdata_valid` out 1: read beat available (registered).
- `rdata_ready` in 1: read beat consumed when valid & ready.
- `rdata` out DATA_W: read beat data (registered).
- `rdata_last` out 1: final beat of the read burst.
- `mem_addr` out ADDR_W: to memory `addr`.
- `mem_wr_enb` out 1: to memory `wr_enb`.
- `mem_wr_data` out DATA_W: to memory `wr_data`.
- `mem_rd_data` in DATA_W: from memory `rd_data` (combinational read of `mem_addr`).
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse when the final beat of a burst completes.

## Operation
- FSM states: IDLE, WR, RD. Registers: `addr_q` (ADDR_W), `cnt_q` (LEN_W), `rdata`, `rdata_valid`, `rdata_last`.
- IDLE: `cmd_ready = !rdata_valid`. On accept: `addr_q <= cmd_addr`, `cnt_q <= cmd_len`, go to WR if `cmd_wr`, else RD.
- WR: `wdata_ready = 1`; `mem_wr_enb = wdata_valid`; `mem_wr_data = wdata`; `mem_addr = addr_q`. Each accepted beat writes the memory at that edge, then `addr_q++` and `cnt_q--`. A beat with `cnt_q==0` returns the FSM to IDLE and pulses `done`. Stalls indefinitely while `wdata_valid=0`.
- RD: `mem_addr = addr_q`; `mem_wr_enb = 0`. The FSM advances on an edge when `!rdata_valid || rdata_ready`. On advance: `rdata <= mem_rd_data`, `rdata_valid <= 1`, `rdata_last <= (cnt_q==0)`, then `addr_q++` and `cnt_q--`. When `cnt_q==0` it returns to IDLE and pulses `done`.
- While stalled in RD, `addr_q` holds.
- `rdata_valid` clears when the beat is consumed and no new beat is captured.
- Outside WR, `wdata_ready=0` and `mem_wr_enb=0`. Outside IDLE, `cmd_ready=0`.
- Address arithmetic is modulo 2^ADDR_W: 0xF+1 wraps to 0x0 with no error unless the macro below is enabled.
- `mem_wr_data = wdata` in all states; it is ignored when `mem_wr_enb=0`.

## Timing
- Reset values:
  - state IDLE, `addr_q=0`, `cnt_q=0`.
  - `cmd_ready=1`, `wdata_ready=0`, `rdata_valid=0`, `rdata=0`, `rdata_last=0`.
  - `mem_addr=0`, `mem_wr_enb=0`, `busy=0`, `done=0`, `err=0`.
- Command accept to first memory access: 1 cycle (next cycle in WR/RD).
- Write throughput: 1 beat/cycle while `wdata_valid=1`.
- Read: data is visible on `rdata` 1 cycle after its address is driven. Throughput is 1 beat/cycle while `rdata_ready=1`.
- `done` asserts in the cycle after the last beat's edge, for exactly 1 cycle.
- After a read burst, the next command is accepted once the last beat has been consumed.
- `rst_n` assertion mid-burst: immediate return to reset values. The burst is abandoned, and memory contents already written are retained.

## Configuration
- Macro `MEM_BURST_WRAP_ERR_EN`.
- Defined: adds output `err` (1 bit, reset 0). On command accept, `err <= (cmd_addr + cmd_len) > 2^ADDR_W-1`, computed at width ADDR_W+1. `err` holds until the next accept. The burst still executes with wrap.
- Undefined: no `err` port; wrap is silent.

## Test plan
- Write burst `addr=0x2`, `len=3`, data 0xA1..0xA4, `wdata_valid` held high -> mem[2..5]=A1..A4, `done` pulses at cycle 5 after accept, `cmd_ready` returns to 1.
- Read burst `addr=0x2`, `len=3`, `rdata_ready=1` -> `rdata` A1,A2,A3,A4 on consecutive cycles, `rdata_last` only on A4, `done` once.
- Read with `rdata_ready` low for 3 cycles on beat 2 -> `rdata` holds A2, `mem_addr` holds 0x4, no beat lost or duplicated.
- Write `addr=0xE`, `len=2`, data 11,22,33 -> mem[E]=11, mem[F]=22, mem[0]=33. With `MEM_BURST_WRAP_ERR_EN` defined, `err=1`. A following `addr=0x0`, `len=0` command clears `err`.
- Write burst with `wdata_valid` gaps of 2 cycles -> exactly `len+1` writes, `mem_wr_enb` never high during gaps.
- Assert `rst_n=0` after beat 1 of a 4-beat read -> all outputs at reset values asynchronously, `cmd_ready=1` after release.
